uart_mem_sequencer: RTL and testbench

- Owns the single data-memory port and sequences three phases: UART load, processor run, UART dump.
- Load: assembles received byte pairs into 16-bit words and writes them from address 0. Run: starts the processor and hands it the memory port. Dump: reads words back and sends each as two bytes.
- Sits between Receiver/Transmitter, processor and DMemory in the top level. It replaces the ad-hoc state logic there.

---
 rtl/uart_mem_sequencer_pkg.sv | 37 +++
 rtl/uart_mem_sequencer_tx_hs.sv | 80 ++++++++
 rtl/uart_mem_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_uart_mem_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mem_sequencer_pkg.sv
// Shared definitions for the UART load / processor run / UART dump sequencer.
package uart_mem_sequencer_pkg;

   localparam int unsigned BYTE_W = 8;

   // Top-level sequencer states.
   typedef logic [3:0] seq_state_t;
   localparam seq_state_t S_IDLE     = 4'd0;
   localparam seq_state_t S_LOAD_LO  = 4'd1;
   localparam seq_state_t S_LOAD_HI  = 4'd2;
   localparam seq_state_t S_RUN      = 4'd3;
   localparam seq_state_t S_DUMP_RD  = 4'd4;
   localparam seq_state_t S_DUMP_LAT = 4'd5;
   localparam seq_state_t S_TX_LO    = 4'd6;
   localparam seq_state_t S_TX_LO_W  = 4'd7;
   localparam seq_state_t S_TX_HI    = 4'd8;
   localparam seq_state_t S_TX_HI_W  = 4'd9;
   localparam seq_state_t S_DONE     = 4'd10;

   // Byte transmit handshake phases.
   typedef logic [1:0] hs_phase_t;
   localparam hs_phase_t HS_IDLE = 2'd0;
   localparam hs_phase_t HS_RISE = 2'd1;
   localparam hs_phase_t HS_FALL = 2'd2;

   // Memory port owner.
   typedef logic mux_sel_t;
   localparam mux_sel_t MUX_SEQ  = 1'b0;
   localparam mux_sel_t MUX_PROC = 1'b1;

   // Little-endian byte pick from a two-byte word.
   function automatic logic [BYTE_W-1:0] word_byte(input logic [2*BYTE_W-1:0] word,
                                                   input logic                hi);
      return hi ? word[2*BYTE_W-1:BYTE_W] : word[BYTE_W-1:0];
   endfunction

endpackage

// File: rtl/uart_mem_sequencer_tx_hs.sv
// Single-byte transmit handshake: wait for an idle transmitter, pulse
// tx_start with the byte, then wait for busy to rise and fall. A transmitter
// that never raises busy within two cycles of tx_start is taken to have
// accepted the byte.
module uart_byte_tx_handshake
   import uart_mem_sequencer_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_i,
   input  logic [BYTE_W-1:0] byte_i,
   input  logic              tx_busy_i,
   output logic              issue_o,
   output logic              done_o,
   output logic              tx_start_o,
   output logic [BYTE_W-1:0] tx_data_o
);

   hs_phase_t         phase_q, phase_d;
   logic [1:0]        wait_q, wait_d;
   logic              tx_start_q, tx_start_d;
   logic [BYTE_W-1:0] tx_data_q, tx_data_d;

   // Handshake next-state: launch, watch for busy rise (with timeout), watch for fall.
   always_comb begin
      phase_d    = phase_q;
      wait_d     = wait_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      issue_o    = 1'b0;
      done_o     = 1'b0;
      case (phase_q)
         HS_IDLE: begin
            if (req_i && !tx_busy_i) begin
               issue_o    = 1'b1;
               tx_start_d = 1'b1;
               tx_data_d  = byte_i;
               wait_d     = '0;
               phase_d    = HS_RISE;
            end
         end
         HS_RISE: begin
            if (tx_busy_i) begin
               phase_d = HS_FALL;
            end else if (wait_q == 2'd2) begin
               done_o  = 1'b1;
               phase_d = HS_IDLE;
            end else begin
               wait_d = wait_q + 2'd1;
            end
         end
         HS_FALL: begin
            if (!tx_busy_i) begin
               done_o  = 1'b1;
               phase_d = HS_IDLE;
            end
         end
         default: phase_d = HS_IDLE;
      endcase
   end

   // Handshake registers; tx_data holds its byte until the next launch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q    <= HS_IDLE;
         wait_q     <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         phase_q    <= phase_d;
         wait_q     <= wait_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
      end
   end

   assign tx_start_o = tx_start_q;
   assign tx_data_o  = tx_data_q;

endmodule

// File: rtl/uart_mem_sequencer.sv
// Owns the data-memory port and sequences UART load, processor run and
// UART dump. Words are little-endian byte pairs in both directions.
module uart_mem_sequencer
   import uart_mem_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned LOAD_WORDS = 65536,
   parameter int unsigned DUMP_WORDS = 16384
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic              tx_busy,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   output logic              proc_start,
   input  logic              proc_end,
   input  logic              proc_read,
   input  logic              proc_write,
   input  logic [ADDR_W-1:0] proc_addr,
   input  logic [DATA_W-1:0] proc_wdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              done
);

   localparam int unsigned      CNT_W     = ADDR_W + 1;
   localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_WORDS - 1);
   localparam logic [CNT_W-1:0] DUMP_LAST = CNT_W'(DUMP_WORDS - 1);

   seq_state_t        state_q, state_d;
   logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
   logic [7:0]        lo_byte_q, lo_byte_d;
   logic [DATA_W-1:0] word_buf_q, word_buf_d;
   logic              seq_read_q, seq_read_d;
   logic              seq_write_q, seq_write_d;
   logic [ADDR_W-1:0] seq_addr_q, seq_addr_d;
   logic [DATA_W-1:0] seq_wdata_q, seq_wdata_d;
   logic              proc_start_q, proc_start_d;
   logic              done_q, done_d;

   logic              hs_req, hs_hi, hs_issue, hs_done;
   logic [7:0]        hs_byte;
   mux_sel_t          mux_sel;

   assign hs_req  = (state_q == S_TX_LO) || (state_q == S_TX_HI);
   assign hs_hi   = (state_q == S_TX_HI) || (state_q == S_TX_HI_W);
   assign hs_byte = word_byte(word_buf_q, hs_hi);

   uart_byte_tx_handshake u_tx_hs (
      .clk        (clk),
      .rst        (rst),
      .req_i      (hs_req),
      .byte_i     (hs_byte),
      .tx_busy_i  (tx_busy),
      .issue_o    (hs_issue),
      .done_o     (hs_done),
      .tx_start_o (tx_start),
      .tx_data_o  (tx_data)
   );

   // Sequencer next-state: load words, run the processor, dump words byte by byte.
   always_comb begin
      state_d      = state_q;
      word_cnt_d   = word_cnt_q;
      lo_byte_d    = lo_byte_q;
      word_buf_d   = word_buf_q;
      seq_read_d   = 1'b0;
      seq_write_d  = 1'b0;
      seq_addr_d   = seq_addr_q;
      seq_wdata_d  = seq_wdata_q;
      proc_start_d = proc_start_q;
      done_d       = done_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d    = S_LOAD_LO;
               word_cnt_d = '0;
               done_d     = 1'b0;
            end
         end
         S_LOAD_LO: begin
            if (rx_valid) begin
               lo_byte_d = rx_data;
               state_d   = S_LOAD_HI;
            end
         end
         S_LOAD_HI: begin
            if (rx_valid) begin
               seq_write_d = 1'b1;
               seq_addr_d  = word_cnt_q[ADDR_W-1:0];
               seq_wdata_d = {rx_data, lo_byte_q};
               if (word_cnt_q == LOAD_LAST) begin
                  word_cnt_d = '0;
                  state_d    = S_RUN;
               end else begin
                  word_cnt_d = word_cnt_q + CNT_W'(1);
                  state_d    = S_LOAD_LO;
               end
            end
         end
         S_RUN: begin
            // proc_start rises one cycle into RUN so the final load write,
            // still in flight on the sequencer side, completes before the
            // processor is handed the port.
            if (!proc_start_q) begin
               proc_start_d = 1'b1;
            end else if (proc_end) begin
               proc_start_d = 1'b0;
               state_d      = S_DUMP_RD;
            end
         end
         S_DUMP_RD:  state_d = S_DUMP_LAT;
         S_DUMP_LAT: begin
            word_buf_d = mem_rdata;
            state_d    = S_TX_LO;
         end
         S_TX_LO:   if (hs_issue) state_d = S_TX_LO_W;
         S_TX_LO_W: if (hs_done)  state_d = S_TX_HI;
         S_TX_HI:   if (hs_issue) state_d = S_TX_HI_W;
         S_TX_HI_W: begin
            if (hs_done) begin
               if (word_cnt_q == DUMP_LAST) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  word_cnt_d = word_cnt_q + CNT_W'(1);
                  state_d    = S_DUMP_RD;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Every entry into DUMP_RD issues exactly one read of the current word.
      if ((state_d == S_DUMP_RD) && (state_q != S_DUMP_RD)) begin
         seq_read_d = 1'b1;
         seq_addr_d = word_cnt_d[ADDR_W-1:0];
      end
   end

   // Sequencer registers with asynchronous return to IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         word_cnt_q   <= '0;
         lo_byte_q    <= '0;
         word_buf_q   <= '0;
         seq_read_q   <= 1'b0;
         seq_write_q  <= 1'b0;
         seq_addr_q   <= '0;
         seq_wdata_q  <= '0;
         proc_start_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         word_cnt_q   <= word_cnt_d;
         lo_byte_q    <= lo_byte_d;
         word_buf_q   <= word_buf_d;
         seq_read_q   <= seq_read_d;
         seq_write_q  <= seq_write_d;
         seq_addr_q   <= seq_addr_d;
         seq_wdata_q  <= seq_wdata_d;
         proc_start_q <= proc_start_d;
         done_q       <= done_d;
      end
   end

   assign mux_sel = ((state_q == S_RUN) && proc_start_q) ? MUX_PROC : MUX_SEQ;

   // Memory port mux: processor passes straight through only while it runs.
   always_comb begin
      if (mux_sel == MUX_PROC) begin
         mem_read  = proc_read;
         mem_write = proc_write;
         mem_addr  = proc_addr;
         mem_wdata = proc_wdata;
      end else begin
         mem_read  = seq_read_q;
         mem_write = seq_write_q;
         mem_addr  = seq_addr_q;
         mem_wdata = seq_wdata_q;
      end
   end

   assign proc_start = proc_start_q;
   assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done       = done_q;

endmodule

// File: tb/tb_uart_mem_sequencer.sv
// Self-checking bench for uart_mem_sequencer: directed and randomized
// load/run/dump sequences against a word-level reference model.
module tb_uart_mem_sequencer;

   localparam int unsigned LW = 4;
   localparam int unsigned DW = 2;

   logic        clk = 1'b0;
   logic        rst, start, rx_valid, tx_busy, tx_start;
   logic [7:0]  rx_data, tx_data;
   logic        proc_start, proc_end, proc_read, proc_write;
   logic [15:0] proc_addr, proc_wdata;
   logic        mem_read, mem_write;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        busy, done;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk = ~clk;

   uart_mem_sequencer #(
      .ADDR_W     (16),
      .DATA_W     (16),
      .LOAD_WORDS (LW),
      .DUMP_WORDS (DW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .tx_busy    (tx_busy),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .proc_start (proc_start),
      .proc_end   (proc_end),
      .proc_read  (proc_read),
      .proc_write (proc_write),
      .proc_addr  (proc_addr),
      .proc_wdata (proc_wdata),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .busy       (busy),
      .done       (done)
   );

   // Data memory: one-cycle read latency.
   logic [15:0] ram [0:65535];
   always @(posedge clk) begin
      if (mem_write) ram[mem_addr] <= mem_wdata;
      if (mem_read)  mem_rdata <= ram[mem_addr];
   end

   // Transmitter: busy for a fixed 10 cycles, or a random 0..6 cycles.
   bit          tx_rand;
   int unsigned busy_left;
   logic [7:0]  tx_held;
   always @(posedge clk) begin
      int unsigned lat;
      if (rst) begin
         busy_left = 0;
         tx_busy  <= 1'b0;
      end else if (tx_start) begin
         lat       = tx_rand ? $urandom_range(0, 6) : 10;
         tx_held   = tx_data;
         busy_left = lat;
         tx_busy  <= (lat != 0);
      end else if (busy_left > 0) begin
         busy_left--;
         if (busy_left == 0) tx_busy <= 1'b0;
      end
   end

   // Observers: record port activity and protocol violations.
   logic [31:0] obs_wr[$];
   logic [7:0]  obs_tx[$];
   logic [15:0] obs_rd[$];
   int unsigned dbl_cnt = 0, ov_cnt = 0, pv_cnt = 0, sb_cnt = 0, st_cnt = 0;
   bit          prev_wr = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         prev_wr = 1'b0;
      end else begin
         if (mem_write && !proc_start) begin
            obs_wr.push_back({mem_addr, mem_wdata});
            if (prev_wr) dbl_cnt++;
         end
         prev_wr = mem_write && !proc_start;
         if (mem_read && !proc_start) obs_rd.push_back(mem_addr);
         if (mem_read && mem_write) ov_cnt++;
         if (proc_start && ({mem_read, mem_write, mem_addr, mem_wdata} !==
                            {proc_read, proc_write, proc_addr, proc_wdata})) pv_cnt++;
         if (tx_start) begin
            obs_tx.push_back(tx_data);
            if (tx_busy) sb_cnt++;
         end
         if (tx_busy && (tx_data !== tx_held)) st_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_tx_start"},   32'(tx_start),   0);
      check({tag, "_tx_data"},    32'(tx_data),    0);
      check({tag, "_proc_start"}, 32'(proc_start), 0);
      check({tag, "_mem_read"},   32'(mem_read),   0);
      check({tag, "_mem_write"},  32'(mem_write),  0);
      check({tag, "_mem_addr"},   32'(mem_addr),   0);
      check({tag, "_busy"},       32'(busy),       0);
      check({tag, "_done"},       32'(done),       0);
   endtask

   // Called at posedge+1; leaves rx_valid high for exactly one cycle per byte.
   task automatic send_byte(input logic [7:0] b, input int unsigned gap);
      if (gap > 0) begin
         rx_valid = 1'b0;
         repeat (gap) @(posedge clk);
         #1;
      end
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk); #1;
   endtask

   logic [15:0] ref_mem [0:255];

   // abort_mode: 0 full sequence, 1 reset during RUN, 2 reset while high byte is in flight.
   task automatic run_seq(input bit directed, input bit pulse_start, input int unsigned abort_mode);
      logic [7:0]  b [2*LW];
      logic [7:0]  exp_tx [2*DW];
      logic [7:0]  a;
      logic [15:0] d;
      logic [31:0] e;
      int unsigned gap, w, nops;
      int unsigned wr_base, tx_base, rd_base, dbl_base, ov_base, pv_base, sb_base, st_base;
      wr_base = obs_wr.size(); tx_base = obs_tx.size(); rd_base = obs_rd.size();
      dbl_base = dbl_cnt; ov_base = ov_cnt; pv_base = pv_cnt; sb_base = sb_cnt; st_base = st_cnt;
      for (int i = 0; i < 2*LW; i++) b[i] = directed ? 8'(32'h11 * (i + 1)) : 8'($urandom);

      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("start_done_clear", 32'(done), 0);
      check("start_busy", 32'(busy), 1);

      for (int i = 0; i < 2*LW; i++) begin
         gap = directed ? 0 : $urandom_range(0, 2);
         if (pulse_start && (i == 3)) start = 1'b1;
         send_byte(b[i], gap);
         start = 1'b0;
      end
      rx_valid = 1'b0;
      for (int k = 0; k < LW; k++) ref_mem[k] = {b[2*k+1], b[2*k]};

      w = 0;
      while (!proc_start && (w < 20)) begin @(posedge clk); #1; w++; end
      check("proc_start_on", 32'(proc_start), 1);
      check("load_wr_count", obs_wr.size() - wr_base, LW);
      for (int k = 0; k < LW; k++) begin
         e = obs_wr[wr_base + k];
         check("load_wr_addr", 32'(e[31:16]), k);
         check("load_wr_data", 32'(e[15:0]), 32'(ref_mem[k]));
      end

      if (abort_mode == 1) begin
         proc_read = 1'b1;
         proc_addr = 16'h0005;
         @(posedge clk); #3;
         rst = 1'b1;
         #1;
         check_outputs_zero("rst_run");
         proc_read = 1'b0;
         proc_addr = '0;
         repeat (2) @(posedge clk);
         #1;
         rst = 1'b0;
         return;
      end

      if (directed) begin
         proc_write = 1'b1; proc_addr = 16'h0001; proc_wdata = 16'hBEEF;
         ref_mem[1] = 16'hBEEF;
         @(posedge clk); #1;
         proc_write = 1'b0;
      end else begin
         nops = $urandom_range(0, 3);
         for (int k = 0; k < int'(nops); k++) begin
            a = 8'($urandom_range(0, 7));
            d = 16'($urandom);
            proc_addr = {8'h00, a};
            if ($urandom_range(0, 1) == 1) begin
               proc_write = 1'b1; proc_wdata = d; ref_mem[a] = d;
            end else begin
               proc_read = 1'b1;
            end
            @(posedge clk); #1;
            proc_write = 1'b0; proc_read = 1'b0;
         end
      end
      if (pulse_start) begin
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         check("run_start_ignored", 32'(proc_start), 1);
         check("run_busy", 32'(busy), 1);
      end
      proc_end = 1'b1;
      @(posedge clk); #1;
      proc_end = 1'b0;
      check("proc_start_off", 32'(proc_start), 0);

      if (abort_mode == 2) begin
         w = 0;
         while (((obs_tx.size() - tx_base) < 2) && (w < 200)) begin @(posedge clk); #1; w++; end
         check("hi_byte_started", obs_tx.size() - tx_base, 2);
         repeat (2) @(posedge clk);
         #1;
         check("hi_wait_busy", 32'(busy), 1);
         #3;
         rst = 1'b1;
         #1;
         check_outputs_zero("rst_tx");
         repeat (2) @(posedge clk);
         #1;
         rst = 1'b0;
         return;
      end

      w = 0;
      while (!done && (w < 1000)) begin @(posedge clk); #1; w++; end
      check("done_set", 32'(done), 1);
      check("busy_clear", 32'(busy), 0);

      for (int i = 0; i < DW; i++) begin
         exp_tx[2*i]   = ref_mem[i][7:0];
         exp_tx[2*i+1] = ref_mem[i][15:8];
      end
      check("tx_count", obs_tx.size() - tx_base, 2*DW);
      for (int j = 0; j < 2*DW; j++) check("tx_byte", 32'(obs_tx[tx_base + j]), 32'(exp_tx[j]));
      check("dump_rd_count", obs_rd.size() - rd_base, DW);
      for (int i = 0; i < DW; i++) check("dump_rd_addr", 32'(obs_rd[rd_base + i]), i);
      check("wr_single_cycle", dbl_cnt - dbl_base, 0);
      check("rd_wr_overlap", ov_cnt - ov_base, 0);
      check("proc_passthru", pv_cnt - pv_base, 0);
      check("tx_start_while_busy", sb_cnt - sb_base, 0);
      check("tx_data_stable", st_cnt - st_base, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = '0;
      proc_end = 1'b0; proc_read = 1'b0; proc_write = 1'b0;
      proc_addr = '0; proc_wdata = '0; tx_rand = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;
      check("idle_busy", 32'(busy), 0);

      run_seq(1'b1, 1'b1, 0);
      run_seq(1'b0, 1'b0, 1);
      run_seq(1'b0, 1'b0, 0);
      run_seq(1'b1, 1'b0, 2);
      run_seq(1'b1, 1'b0, 0);
      tx_rand = 1'b1;
      for (int r = 0; r < 6; r++) run_seq(1'b0, 1'($urandom_range(0, 1)), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
